// File: rtl/mte_scheduler_if.sv
// mte_scheduler_if: host-side channels of the MTE scheduler.
//   req0_*  : encrypt request channel (valid/ready/data)
//   req1_*  : decrypt request channel (valid/ready/data)
//   rsp_*   : in-order result channel (valid/ready/data/id)
// master = host side (drives requests, consumes results)
// slave  = scheduler side
interface mte_scheduler_if #(
  parameter int WIDTH = 256
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/mte_scheduler.sv
// mte_scheduler: sequences a shared fixed-latency MTE encrypt/decrypt
// pipeline between requester 0 (encrypt) and requester 1 (decrypt).
// Owns the active key, arbitrates one issue per cycle, tracks in-flight
// operations and returns results in issue order through a result FIFO.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   key_load, key_in      : install a new active key
//   key_busy              : key change pending / in progress
//   host (slave modport)  : req0/req1 request channels, rsp result channel
//   mte_key/mte_in/mte_sel: key, data and direction to the MTE datapath
//   mte_valid_key, mte_out: MTE key-usable flag and result
// Build option: define MTE_SCHED_PRIORITY_EN for strict priority to
// requester 1; otherwise round-robin arbitration.
module mte_scheduler #(
  parameter int WIDTH      = 256,
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  output logic             key_busy,
  mte_scheduler_if.slave   host,
  output logic [WIDTH-1:0] mte_key,
  output logic [WIDTH-1:0] mte_in,
  output logic             mte_sel,
  input  logic             mte_valid_key,
  input  logic [WIDTH-1:0] mte_out
);
  localparam int IW = $clog2(LATENCY + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = ((IW > NW) ? IW : NW) + 1;

  typedef enum logic [1:0] {NOKEY, LOAD, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             key_accept, issue_en, credit_ok;
  logic             grant0, grant1, grant, push, pop;
  logic [IW-1:0]    inflight;
  logic [NW-1:0]    count;
  logic [CW-1:0]    used;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LATENCY:0] iss_vld_p, iss_id_p;
  logic [WIDTH-1:0] pend_key;
  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic             mem_id   [FIFO_DEPTH];

  // Credit covers both in-flight ops and queued results, so every issued
  // op is guaranteed a FIFO slot when it emerges from the pipeline.
  assign used      = CW'(inflight) + CW'(count);
  assign credit_ok = (used < CW'(FIFO_DEPTH));
  assign push      = iss_vld_p[LATENCY];
  assign pop       = host.rsp_valid && host.rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= NOKEY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NOKEY:   if (key_load) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (key_load) state_nxt = (inflight == '0) ? LOAD : DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = LOAD;
      default: state_nxt = NOKEY;
    endcase
  end

  // No issue on the cycle a key change is accepted, so nothing issued
  // under the old key can overlap the key swap.
  always_comb begin
    key_busy   = (state == LOAD) || (state == DRAIN);
    key_accept = key_load && ((state == NOKEY) || (state == RUN));
    issue_en   = (state == RUN) && mte_valid_key && credit_ok && !key_accept;
  end

`ifdef MTE_SCHED_PRIORITY_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (issue_en) begin
      grant1 = host.req1_valid;
      grant0 = host.req0_valid && !host.req1_valid;
    end
  end
`else
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (issue_en) begin
      if (host.req0_valid && host.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = host.req0_valid;
        grant1 = host.req1_valid;
      end
    end
  end

  // Reset value 1 makes requester 0 the first winner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   last_grant <= 1'b1;
    else if (grant) last_grant <= grant1;
  end
`endif

  assign grant           = grant0 || grant1;
  assign host.req0_ready = grant0;
  assign host.req1_ready = grant1;

  // Issue stage / tracker / FIFO control
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_vld_p <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mte_in    <= '0;
      mte_sel   <= 1'b0;
      mte_key   <= '0;
    end else begin
      iss_vld_p <= {iss_vld_p[LATENCY-1:0], grant};
      inflight  <= inflight + IW'(grant) - IW'(push);
      count     <= count + NW'(push) - NW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (grant) begin
        mte_in  <= grant1 ? host.req1_data : host.req0_data;
        mte_sel <= grant1;
      end
      if (state == LOAD) mte_key <= pend_key;
    end
  end

  // Data-only storage; meaning is carried by the control state above.
  always_ff @(posedge clock) begin
    if (key_accept) pend_key <= key_in;
    iss_id_p <= {iss_id_p[LATENCY-1:0], grant1};
    if (push) begin
      mem_data[wr_ptr] <= mte_out;
      mem_id[wr_ptr]   <= iss_id_p[LATENCY];
    end
  end

  // Result outputs read zero while the FIFO is empty.
  assign host.rsp_valid = (count != '0);
  assign host.rsp_data  = host.rsp_valid ? mem_data[rd_ptr] : '0;
  assign host.rsp_id    = host.rsp_valid ? mem_id[rd_ptr]   : 1'b0;
endmodule

// File: tb/tb_mte_scheduler.sv
// tb_mte_scheduler: directed bench for mte_scheduler with a behavioural
// MTE datapath (encrypt = data ^ key, decrypt = data + key).
module tb_mte_scheduler;
  localparam int W = 256;
  localparam int L = 10;
  localparam int D = 16;

  localparam logic [W-1:0] KEY7 = {64{4'h7}};
  localparam logic [W-1:0] KEY2 = {64{4'h2}};
  localparam logic [W-1:0] DA   = {32{8'hA5}};
  localparam logic [W-1:0] DB   = {32{8'h3C}};

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [W-1:0] key_in = '0;
  logic         key_busy;
  logic [W-1:0] mte_key, mte_in, mte_out;
  logic         mte_sel;
  logic         mte_valid_key = 1'b1;

  mte_scheduler_if #(.WIDTH(W)) bus ();

  mte_scheduler #(.WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .key_load(key_load), .key_in(key_in),
    .key_busy(key_busy), .host(bus), .mte_key(mte_key), .mte_in(mte_in),
    .mte_sel(mte_sel), .mte_valid_key(mte_valid_key), .mte_out(mte_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural MTE datapath: L register stages from mte_in to mte_out.
  logic [W-1:0] pipe [L];
  always @(posedge clock) begin
    pipe[0] <= mte_sel ? (mte_in + mte_key) : (mte_in ^ mte_key);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mte_out = pipe[L-1];

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           cyc;
  } ev_t;
  ev_t gq[$];
  ev_t rq[$];

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.req0_valid && bus.req0_ready) gq.push_back('{1'b0, bus.req0_data, cyc});
      if (bus.req1_valid && bus.req1_ready) gq.push_back('{1'b1, bus.req1_data, cyc});
      if (bus.rsp_valid && bus.rsp_ready) rq.push_back('{bus.rsp_id, bus.rsp_data, cyc});
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic exp_id;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.rsp_ready  = 1'b0;

    // ---- reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_mte_key", mte_key, 0);
    chk("rst_mte_in", mte_in, 0);
    chk("rst_mte_sel", mte_sel, 0);
    chk("rst_key_busy", key_busy, 0);
    reset_n = 1'b1;
    tick();

    // ---- NOKEY: no issue
    bus.req0_valid = 1'b1;
    #1 chk("nokey_ready0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;

    // ---- key install
    key_in = KEY7; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("load_key_busy", key_busy, 1);
    tick();
    chk("run_key_busy", key_busy, 0);
    chk("run_mte_key", mte_key, KEY7);

    // ---- both requesters valid for 8 cycles
    gq.delete(); rq.delete();
    bus.rsp_ready = 1'b1;
    bus.req0_data = DA; bus.req1_data = DB;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (8) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (L + 12) tick();
    chk("rr_grants", gq.size(), 8);
    chk("rr_rsps", rq.size(), 8);
    for (int i = 0; i < 8; i++) begin
`ifdef MTE_SCHED_PRIORITY_EN
      exp_id = 1'b1;
`else
      exp_id = i[0];
`endif
      if (i < gq.size()) chk("rr_grant_id", gq[i].id, exp_id);
      if (i < rq.size()) begin
        chk("rr_rsp_id", rq[i].id, exp_id);
        chk("rr_rsp_data", rq[i].data, exp_id ? (DB + KEY7) : (DA ^ KEY7));
      end
    end

    // ---- single requester, 5 back-to-back ops
    gq.delete(); rq.delete();
    bus.req0_data = 256'h1; bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("b2b_ready0", bus.req0_ready, 1);
      tick();
      chk("b2b_mte_sel", mte_sel, 0);
      chk("b2b_mte_in", mte_in, 256'h1);
    end
    bus.req0_valid = 1'b0;
    repeat (L + 8) tick();
    chk("b2b_grants", gq.size(), 5);
    chk("b2b_rsps", rq.size(), 5);
    if (gq.size() == 5 && rq.size() == 5) begin
      chk("b2b_latency", rq[0].cyc - gq[0].cyc, L + 2);
      for (int i = 0; i < 5; i++) begin
        chk("b2b_rsp_id", rq[i].id, 0);
        chk("b2b_rsp_data", rq[i].data, KEY7 ^ 256'h1);
        chk("b2b_rsp_cycle", rq[i].cyc - rq[0].cyc, i);
      end
    end

    // ---- backpressure: credit limits issue to FIFO depth
    gq.delete(); rq.delete();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.req0_data = W'(1000 + k);
      tick();
    end
    chk("bp_grants", gq.size(), D);
    chk("bp_ready0_low", bus.req0_ready, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      bus.req0_data = W'(2000 + k);
      tick();
    end
    bus.req0_valid = 1'b0;
    repeat (L + 40) tick();
    chk("bp_resumed", gq.size() > D, 1);
    chk("bp_no_loss", rq.size(), gq.size());
    bad = 0;
    for (int i = 0; i < rq.size() && i < gq.size(); i++)
      if (rq[i].data !== (gq[i].data ^ KEY7) || rq[i].id !== 1'b0) bad++;
    chk("bp_order", bad, 0);

    // ---- key change with 4 ops in flight
    gq.delete(); rq.delete();
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req0_data = W'(3000 + k);
      tick();
    end
    bus.req0_valid = 1'b0;
    key_in = KEY2; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("drain_key_busy", key_busy, 1);
    bus.req0_data = W'(4000); bus.req0_valid = 1'b1;
    bad = 0;
    for (int n = 0; n < 40 && key_busy; n++) begin
      if (bus.req0_ready) bad++;
      tick();
    end
    chk("drain_no_issue", bad, 0);
    chk("drain_done", key_busy, 0);
    chk("drain_new_key", mte_key, KEY2);
    chk("drain_old_rsps", rq.size(), 4);
    for (int i = 0; i < 4 && i < rq.size(); i++)
      chk("drain_old_key_data", rq[i].data, W'(3000 + i) ^ KEY7);
    #1 chk("drain_ready_after", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    repeat (L + 4) tick();
    chk("newkey_rsps", rq.size(), 5);
    if (rq.size() == 5) chk("newkey_data", rq[4].data, W'(4000) ^ KEY2);

    // ---- mte_valid_key low stalls issue
    mte_valid_key = 1'b0; bus.req0_valid = 1'b1;
    #1 chk("nokeyvalid_ready0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0; mte_valid_key = 1'b1;
    tick();

    // ---- reset with 3 in flight and 2 FIFO entries
    gq.delete(); rq.delete();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.req0_data = W'(5000 + k);
      tick();
    end
    bus.req0_valid = 1'b0;
    repeat (L + 4) tick();
    chk("hold_rsp_valid", bus.rsp_valid, 1);
    chk("hold_rsp_data0", bus.rsp_data, W'(5000) ^ KEY2);
    tick();
    chk("hold_rsp_data1", bus.rsp_data, W'(5000) ^ KEY2);
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req0_data = W'(6000 + k);
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready0", bus.req0_ready, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
    chk("mid_rst_rsp_id", bus.rsp_id, 0);
    chk("mid_rst_mte_key", mte_key, 0);
    chk("mid_rst_mte_in", mte_in, 0);
    chk("mid_rst_mte_sel", mte_sel, 0);
    chk("mid_rst_key_busy", key_busy, 0);
    tick();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 25; n++) begin
      if (bus.rsp_valid || bus.req0_ready) bad++;
      tick();
    end
    bus.req0_valid = 1'b0;
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_no_rsps", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
